// File: rtl/sc_pkg.sv
// Shared types and default constants for the stochastic window controller.
package sc_pkg;

   // Width of one SNG lane operand.
   localparam int LANE_W = 4;

   // Default window configuration.
   localparam int SC_LANES   = 4;
   localparam int SC_WIN_LEN = 16;
   localparam int SC_LAT     = 2;
   localparam int SC_CNT_W   = 5;

   // Width of the bit index and of the start-to-stream wait counter.
   localparam int IDX_W  = 4;
   localparam int WAIT_W = 3;

   // Controller sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_t;

   // Smallest counter width able to hold a full window of ones.
   function automatic int cnt_width(input int win_len);
      int w;
      w = 1;
      while ((2 ** w) - 1 < win_len) w++;
      return w;
   endfunction

endpackage

// File: rtl/sc_bit_counter.sv
// Ones-counter for the stochastic product stream, with synchronous clear.
module sc_bit_counter
   import sc_pkg::*;
#(
   parameter int CNT_W = SC_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic             bit_in,
   output logic [CNT_W-1:0] count
);

   // Zero-extended increment so the add stays at the counter width.
   logic [CNT_W-1:0] inc;
   assign inc = {{(CNT_W-1){1'b0}}, bit_in};

   // Clear wins over counting; the counter is sized so it can never wrap.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + inc;
      end
   end

endmodule

// File: rtl/sng_window_ctrl.sv
// Sequences a bank of SNG lanes through one stochastic window: accepts an
// operand vector, pulses start, counts the returned product bits over the
// window and hands the ones-count back over a result handshake.
module sng_window_ctrl
   import sc_pkg::*;
#(
   parameter int LANES   = SC_LANES,
   parameter int WIN_LEN = SC_WIN_LEN,
   parameter int LAT     = SC_LAT,
   parameter int CNT_W   = SC_CNT_W
) (
   input  logic                      i_clk_swc,
   input  logic                      i_rst_swc,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic [LANES*LANE_W-1:0]   i_req_data,
   input  logic                      i_abort,
   output logic [LANES*LANE_W-1:0]   o_sng_data,
   output logic                      o_sng_start,
   output logic                      o_sng_stop,
   input  logic                      i_sc_bit,
   output logic                      o_win_active,
   output logic [IDX_W-1:0]          o_bit_idx,
   output logic                      o_res_valid,
   input  logic                      i_res_ready,
   output logic [CNT_W-1:0]          o_res_count,
   output logic                      o_res_aborted
);

   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIN_LEN - 1);
   localparam logic [WAIT_W-1:0] LAT_LOAD = WAIT_W'(LAT);

   state_t            state_q;
   logic [WAIT_W-1:0] wait_q;

   logic accept;
   logic abort_hit;
   logic cnt_clear;
   logic cnt_en;

   // Request acceptance and abort qualification; abort only matters while
   // the lanes are armed or streaming.
   assign o_req_ready = (state_q == IDLE);
   assign accept      = i_req_valid && o_req_ready;
   assign abort_hit   = i_abort && ((state_q == ARM) || (state_q == RUN));

   // The count restarts on acceptance and only takes bits from non-aborted
   // RUN edges, so the abort-cycle bit is excluded.
   assign cnt_clear = accept;
   assign cnt_en    = (state_q == RUN) && !i_abort;

   sc_bit_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk    (i_clk_swc),
      .rst    (i_rst_swc),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .bit_in (i_sc_bit),
      .count  (o_res_count)
   );

   // Window FSM with registered pulse, index and result outputs.
   // NOTE: the reset is asynchronous, so a mid-window reset drops every
   // output at once without waiting for a clock edge and issues no stop.
   always_ff @(posedge i_clk_swc or posedge i_rst_swc) begin
      if (i_rst_swc) begin
         state_q       <= IDLE;
         wait_q        <= '0;
         o_sng_data    <= '0;
         o_sng_start   <= 1'b0;
         o_sng_stop    <= 1'b0;
         o_win_active  <= 1'b0;
         o_bit_idx     <= '0;
         o_res_valid   <= 1'b0;
         o_res_aborted <= 1'b0;
      end else begin
         // Start and stop are single-cycle pulses unless re-armed below.
         o_sng_start <= 1'b0;
         o_sng_stop  <= 1'b0;

         if (abort_hit) begin
            // Abort beats every other event, including the final sample.
            o_sng_stop    <= 1'b1;
            o_res_aborted <= 1'b1;
            o_res_valid   <= 1'b1;
            o_win_active  <= 1'b0;
            o_bit_idx     <= '0;
            state_q       <= HOLD;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (accept) begin
                     o_sng_data    <= i_req_data;
                     o_res_aborted <= 1'b0;
                     o_sng_start   <= 1'b1;
                     o_bit_idx     <= '0;
                     wait_q        <= LAT_LOAD;
                     if (LAT == 0) begin
                        o_win_active <= 1'b1;
                        state_q      <= RUN;
                     end else begin
                        state_q <= ARM;
                     end
                  end
               end

               ARM: begin
                  // The last wait tick lands on edge E(LAT), where RUN begins.
                  if (wait_q <= WAIT_W'(1)) begin
                     wait_q       <= '0;
                     o_win_active <= 1'b1;
                     state_q      <= RUN;
                  end else begin
                     wait_q <= wait_q - WAIT_W'(1);
                  end
               end

               RUN: begin
                  if (o_bit_idx == LAST_IDX) begin
                     o_bit_idx    <= '0;
                     o_win_active <= 1'b0;
                     o_res_valid  <= 1'b1;
                     state_q      <= HOLD;
                  end else begin
                     o_bit_idx <= o_bit_idx + IDX_W'(1);
                  end
               end

               HOLD: begin
                  // Result holds until consumed; no new request this edge.
                  if (i_res_ready) begin
                     o_res_valid <= 1'b0;
                     state_q     <= IDLE;
                  end
               end

               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sng_window_ctrl.sv
// Self-checking bench for sng_window_ctrl: windows are described by their
// acceptance edge E0, the per-edge stream bits and an optional abort edge;
// expected outputs are derived from edge arithmetic on that description.
module tb_sng_window_ctrl;
   import sc_pkg::*;

   localparam int LANES   = 4;
   localparam int WIN_LEN = 16;
   localparam int LAT     = 2;
   localparam int CNT_W   = 5;
   localparam int DW      = LANES * 4;

   logic             i_clk_swc = 1'b0;
   logic             i_rst_swc;
   logic             i_req_valid;
   logic             o_req_ready;
   logic [DW-1:0]    i_req_data;
   logic             i_abort;
   logic [DW-1:0]    o_sng_data;
   logic             o_sng_start;
   logic             o_sng_stop;
   logic             i_sc_bit;
   logic             o_win_active;
   logic [3:0]       o_bit_idx;
   logic             o_res_valid;
   logic             i_res_ready;
   logic [CNT_W-1:0] o_res_count;
   logic             o_res_aborted;

   int checks   = 0;
   int failures = 0;

   sng_window_ctrl #(
      .LANES   (LANES),
      .WIN_LEN (WIN_LEN),
      .LAT     (LAT),
      .CNT_W   (CNT_W)
   ) dut (
      .i_clk_swc     (i_clk_swc),
      .i_rst_swc     (i_rst_swc),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_data    (i_req_data),
      .i_abort       (i_abort),
      .o_sng_data    (o_sng_data),
      .o_sng_start   (o_sng_start),
      .o_sng_stop    (o_sng_stop),
      .i_sc_bit      (i_sc_bit),
      .o_win_active  (o_win_active),
      .o_bit_idx     (o_bit_idx),
      .o_res_valid   (o_res_valid),
      .i_res_ready   (i_res_ready),
      .o_res_count   (o_res_count),
      .o_res_aborted (o_res_aborted)
   );

   always #5 i_clk_swc = ~i_clk_swc;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   // Advance past the next rising edge and settle before sampling.
   task automatic step();
      @(posedge i_clk_swc);
      #1;
   endtask

   // Checks every reset value; used both at power-up and after a mid-run reset.
   task automatic check_reset_values(input string tag);
      checks++;
      if (o_req_ready !== 1'b1) begin failures++; $display("FAIL %s req_ready: got %b want 1", tag, o_req_ready); end
      checks++;
      if (o_sng_data !== '0) begin failures++; $display("FAIL %s sng_data: got %h want 0", tag, o_sng_data); end
      checks++;
      if (o_sng_start !== 1'b0 || o_sng_stop !== 1'b0) begin failures++; $display("FAIL %s start/stop: got %b%b want 00", tag, o_sng_start, o_sng_stop); end
      checks++;
      if (o_win_active !== 1'b0 || o_bit_idx !== 4'd0) begin failures++; $display("FAIL %s active/idx: got %b/%0d want 0/0", tag, o_win_active, o_bit_idx); end
      checks++;
      if (o_res_valid !== 1'b0 || o_res_count !== '0 || o_res_aborted !== 1'b0) begin failures++; $display("FAIL %s result: got v=%b c=%0d a=%b want 0/0/0", tag, o_res_valid, o_res_count, o_res_aborted); end
   endtask

   // One window. mode: 0 random bits, 1 all ones, 2 alternating on samples.
   // abort_k: edge index of abort (-1 none). reset_k: edge after which the
   // task returns early so the caller can reset (-1 none).
   task automatic run_window(input logic [DW-1:0] data, input int mode, input int abort_k,
                             input int hold_cycles, input bit keep_valid, input int reset_k);
      logic bits [0:40];
      int   last_k;
      bit   aborted;
      int   exp_cnt;
      bit   exp_active;
      int   exp_idx;

      aborted = (abort_k >= 0);
      last_k  = aborted ? abort_k : LAT + WIN_LEN;
      for (int j = 0; j <= 40; j++) begin
         case (mode)
            0:       bits[j] = 1'($urandom_range(0, 1));
            1:       bits[j] = 1'b1;
            default: bits[j] = (j > LAT) ? (((j - LAT - 1) % 2) == 0) : 1'b0;
         endcase
      end
      // Samples land on edges E(LAT+1)..E(LAT+WIN_LEN); an abort edge is not counted.
      exp_cnt = 0;
      for (int j = LAT + 1; j <= last_k; j++) begin
         if (!(aborted && j == last_k)) exp_cnt += int'(bits[j]);
      end

      i_req_data  = data;
      i_req_valid = 1'b1;
      i_sc_bit    = bits[0];
      i_abort     = 1'b0;
      i_res_ready = 1'b0;

      for (int k = 0; k <= last_k; k++) begin
         step();
         if (!keep_valid) i_req_valid = 1'b0;
         exp_active = (k >= LAT) && (k < last_k);
         exp_idx    = exp_active ? (k - LAT) : 0;
         checks++;
         if (o_sng_start !== (k == 0)) begin failures++; $display("FAIL start E%0d: got %b want %b", k, o_sng_start, k == 0); end
         checks++;
         if (o_sng_stop !== (aborted && k == last_k)) begin failures++; $display("FAIL stop E%0d: got %b want %b", k, o_sng_stop, aborted && k == last_k); end
         checks++;
         if (o_win_active !== exp_active) begin failures++; $display("FAIL win_active E%0d: got %b want %b", k, o_win_active, exp_active); end
         checks++;
         if (o_bit_idx !== 4'(exp_idx)) begin failures++; $display("FAIL bit_idx E%0d: got %0d want %0d", k, o_bit_idx, exp_idx); end
         checks++;
         if (o_res_valid !== (k == last_k)) begin failures++; $display("FAIL res_valid E%0d: got %b want %b", k, o_res_valid, k == last_k); end
         checks++;
         if (o_req_ready !== 1'b0 || o_sng_data !== data) begin failures++; $display("FAIL busy E%0d: got ready=%b data=%h want 0/%h", k, o_req_ready, o_sng_data, data); end
         if (k == reset_k) return;
         i_sc_bit = bits[k + 1];
         i_abort  = (k + 1 == abort_k);
      end
      i_abort = 1'b0;

      checks++;
      if (o_res_count !== CNT_W'(exp_cnt) || o_res_aborted !== aborted) begin
         failures++;
         $display("FAIL result: got count=%0d aborted=%b want %0d/%b", o_res_count, o_res_aborted, exp_cnt, aborted);
      end

      for (int h = 0; h < hold_cycles; h++) begin
         i_sc_bit = 1'($urandom_range(0, 1));
         i_abort  = 1'($urandom_range(0, 1));
         step();
         checks++;
         if (o_res_valid !== 1'b1 || o_res_count !== CNT_W'(exp_cnt) || o_res_aborted !== aborted) begin
            failures++;
            $display("FAIL hold %0d: got v=%b c=%0d a=%b want 1/%0d/%b", h, o_res_valid, o_res_count, o_res_aborted, exp_cnt, aborted);
         end
         checks++;
         if (o_req_ready !== 1'b0 || o_sng_start !== 1'b0 || o_sng_stop !== 1'b0) begin
            failures++;
            $display("FAIL hold %0d pulses: got ready=%b start=%b stop=%b want 000", h, o_req_ready, o_sng_start, o_sng_stop);
         end
      end
      i_abort     = 1'b0;
      i_res_ready = 1'b1;
      step();
      i_res_ready = 1'b0;
      checks++;
      if (o_res_valid !== 1'b0 || o_req_ready !== 1'b1 || o_sng_start !== 1'b0) begin
         failures++;
         $display("FAIL release: got valid=%b ready=%b start=%b want 0/1/0", o_res_valid, o_req_ready, o_sng_start);
      end
      checks++;
      if (o_sng_data !== data) begin failures++; $display("FAIL data hold: got %h want %h", o_sng_data, data); end
   endtask

   task automatic test_reset();
      i_rst_swc   = 1'b1;
      i_req_valid = 1'b0;
      i_req_data  = '0;
      i_abort     = 1'b0;
      i_sc_bit    = 1'b0;
      i_res_ready = 1'b0;
      #3;
      check_reset_values("reset");
      #9;
      i_rst_swc = 1'b0;
      step();
      check_reset_values("after_reset");
   endtask

   task automatic test_full_ones();
      run_window(16'hA5C3, 1, -1, 0, 1'b0, -1);
   endtask

   task automatic test_alternating();
      run_window(16'h1234, 2, -1, 2, 1'b0, -1);
   endtask

   task automatic test_abort_run();
      // Abort edge where bit_idx reads 5, after five sampled ones.
      run_window(16'hBEEF, 1, LAT + 6, 1, 1'b0, -1);
   endtask

   task automatic test_abort_arm();
      // Abort in the start-pulse cycle: stop follows once start has fallen.
      run_window(16'h0F0F, 1, 1, 0, 1'b0, -1);
   endtask

   task automatic test_abort_final();
      run_window(16'h7777, 1, LAT + WIN_LEN, 0, 1'b0, -1);
   endtask

   task automatic test_abort_idle();
      i_abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (o_sng_stop !== 1'b0 || o_req_ready !== 1'b1 || o_res_valid !== 1'b0 || o_win_active !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle %0d: got stop=%b ready=%b valid=%b active=%b want 0/1/0/0",
                     i, o_sng_stop, o_req_ready, o_res_valid, o_win_active);
         end
      end
      i_abort = 1'b0;
   endtask

   task automatic test_back_pressure();
      // Request stays valid through a long hold; the follow-up window must
      // only be accepted on the edge after the result is consumed.
      run_window(16'hC0DE, 0, -1, 10, 1'b1, -1);
      run_window(16'hD00D, 0, -1, 0, 1'b0, -1);
   endtask

   task automatic test_reset_mid_run();
      run_window(16'h5A5A, 1, -1, 0, 1'b0, LAT + 7);
      i_abort     = 1'b0;
      i_req_valid = 1'b0;
      #3;
      i_rst_swc = 1'b1;
      #1;
      check_reset_values("mid_reset");
      #2;
      i_rst_swc = 1'b0;
      step();
      check_reset_values("mid_release");
      run_window(16'h9182, 0, -1, 1, 1'b0, -1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         int ak;
         ak = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, LAT + WIN_LEN));
         run_window(DW'($urandom), 0, ak, int'($urandom_range(0, 3)), 1'b0, -1);
         repeat ($urandom_range(0, 2)) step();
      end
   endtask

   initial begin
      test_reset();
      test_full_ones();
      test_alternating();
      test_abort_run();
      test_abort_arm();
      test_abort_final();
      test_abort_idle();
      test_back_pressure();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sng_window_ctrl.md
Name: sng_window_ctrl

Overview:
- Sequences a bank of SNG lanes through one stochastic window.
- Accepts an operand vector over a valid/ready handshake, latches it onto the lanes' 4-bit inputs and pulses start.
- Counts the stochastic product bit returned by the downstream datapath over WIN_LEN bit-cycles.
- Returns the ones-count over a second valid/ready handshake. Supports abort mid-window.

Parameters:
LANES, 4, number of SNG lanes driven (4-bit operand each)
WIN_LEN, 16, stream bits sampled per window (2..16)
LAT, 2, cycles from the end of the start pulse to the first valid i_sc_bit (0..7)
CNT_W, 5, result width; 2^CNT_W-1 >= WIN_LEN

Ports:
i_clk_swc  in  1  clock
i_rst_swc  in  1  asynchronous active-high reset
i_req_valid  in  1  operand vector valid
o_req_ready  out  1  controller can accept operands
i_req_data  in  LANES*4  operands; lane n at bits [4n+3:4n]
i_abort  in  1  terminate current window
o_sng_data  out  LANES*4  latched operands to the SNG lanes
o_sng_start  out  1  one-cycle start pulse to all lanes
o_sng_stop  out  1  one-cycle stop pulse to all lanes (abort only)
i_sc_bit  in  1  stochastic product bit from the datapath
o_win_active  out  1  i_sc_bit is sampled at the next edge
o_bit_idx  out  4  index of the bit sampled at the next edge
o_res_valid  out  1  result available
i_res_ready  in  1  consumer takes the result
o_res_count  out  CNT_W  ones-count of the window
o_res_aborted  out  1  result is partial (window aborted)

Behaviour:
- Clock and reset: one clock, i_clk_swc. Reset i_rst_swc is asynchronous, active-high.
- Reset values: state IDLE, o_sng_data=0, o_sng_start=0, o_sng_stop=0, o_res_valid=0, o_res_count=0, o_res_aborted=0, o_bit_idx=0, o_win_active=0.
- o_req_ready is decoded from the state register (high only in IDLE), so it reads 1 during and after reset.
- States: IDLE, ARM, RUN, HOLD.
- IDLE:
  - o_req_ready=1.
  - At acceptance edge E0 (i_req_valid & o_req_ready): latch i_req_data into o_sng_data, clear the count and aborted flag, set o_sng_start=1 for exactly cycle E0..E1, load the wait counter with LAT, go to ARM.
  - If LAT=0, go directly to RUN.
- ARM:
  - Decrement the wait counter each edge.
  - Reaching 0 moves to RUN, so RUN begins after edge E(LAT).
- RUN:
  - o_win_active=1.
  - Each edge: count += i_sc_bit, bit_idx++.
  - Samples are taken at edges E(LAT+1) .. E(LAT+WIN_LEN).
  - On the sample with bit_idx==WIN_LEN-1: go to HOLD, o_res_valid=1 from edge E(LAT+WIN_LEN).
  - bit_idx returns to 0.
- HOLD:
  - o_res_count and o_res_aborted stay stable while o_res_valid & !i_res_ready.
  - At the edge with i_res_ready=1: o_res_valid=0, go to IDLE.
  - The next request is accepted at the following edge at the earliest. There is no request/result overlap.
- Abort:
  - Applies only when i_abort=1 in ARM or RUN.
  - At that edge: o_sng_stop=1 for one cycle, o_res_aborted=1, go to HOLD with o_res_valid=1.
  - The count excludes the i_sc_bit of the abort cycle.
  - i_abort in IDLE or HOLD is ignored.
- Simultaneous events:
  - Abort on the final RUN sample edge: abort wins, the final bit is not counted, aborted=1.
  - Abort in the start-pulse cycle (ARM): o_sng_stop asserts the following cycle, after o_sng_start has deasserted.
- The count saturates never (CNT_W is sized by the parameter rule). No wrap is possible.
- Reset mid-operation: immediate return to reset values. Any pending result is discarded. No stop pulse is issued.
- o_sng_data holds its value until the next acceptance, including through HOLD and IDLE.

Decomposition:
- Package sc_pkg:
  - state enum (IDLE, ARM, RUN, HOLD)
  - default constants SC_WIN_LEN=16, SC_LAT=2, SC_CNT_W=5
  - LANE_W=4
- Sub-module sc_bit_counter: clear/enable ones-counter of width CNT_W. It is the natural split.
- The FSM, handshake and pulse generation stay in sng_window_ctrl.

Test Plan:
- Full-ones window: accept at E0, i_sc_bit=1 constantly, LAT=2 → o_sng_start high E0..E1, o_win_active high E2..E18, o_res_valid at E18, count=16, aborted=0.
- Alternating stream: i_sc_bit = 1,0,1,0... on the sampled edges → count=8. o_bit_idx steps 0..15, then returns to 0.
- Abort in RUN: i_abort with bit_idx=5 after 5 ones sampled → o_sng_stop single-cycle pulse, count=5, aborted=1, o_res_valid=1 the next cycle.
- Back-pressure: i_res_ready=0 for 10 cycles after a result, and a new i_req_valid is held high → result stable, o_req_ready=0. The request is accepted one edge after i_res_ready=1.
- Abort on the final sample edge (bit_idx=15, 15 ones counted) → count=15, aborted=1. Abort in IDLE → no effect, no stop pulse.
- Reset asserted mid-RUN at bit_idx=7 → all outputs return to reset values asynchronously, o_req_ready=1. After release, a new window runs correctly from E0.
